// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : muldiv_pkg                                                 |
// | Purpose   : Shared encodings for the HI/LO multiply/divide engine:     |
// |             operation codes, FSM states and the default data width.    |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : muldiv_iter                                                |
// | Purpose   : One combinational iteration of the HI/LO engine.           |
// |             Multiply: radix-2 shift-add on {part_hi, part_lo}.         |
// |             Divide  : restoring subtract, one quotient bit per step    |
// |                       (only when HILO_MULDIV_DIV_EN is defined).       |
// | Ports     : is_div   - select divide step (divide builds only)         |
// |             part_hi  - upper accumulator / partial remainder (W+1)     |
// |             part_lo  - multiplier bits / dividend-quotient bits (W)    |
// |             operand  - multiplicand or divisor magnitude (W)           |
// |             nxt_hi, nxt_lo - accumulator after this iteration          |
// | Config    : HILO_MULDIV_DIV_EN                                         |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef HILO_MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH:0]   part_hi,
  input  logic [WIDTH-1:0] part_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  // part_hi[WIDTH] is always 0 during a multiply, so the sum never
  // exceeds WIDTH+1 bits.
  logic [WIDTH:0] sum;
  assign sum = part_hi + {1'b0, (part_lo[0] ? operand : {WIDTH{1'b0}})};

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;
  assign shifted = {part_hi[WIDTH-1:0], part_lo[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, operand});
  assign diff    = shifted - {1'b0, operand};
`endif

  always_comb begin
    nxt_hi = {1'b0, sum[WIDTH:1]};
    nxt_lo = {sum[0], part_lo[WIDTH-1:1]};
`ifdef HILO_MULDIV_DIV_EN
    if (is_div) begin
      nxt_hi = ge ? diff : shifted;
      nxt_lo = {part_lo[WIDTH-2:0], ge};
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : hilo_muldiv_unit                                           |
// | Purpose   : Iterative MULT/MULTU/DIV/DIVU engine holding the           |
// |             architectural HI/LO pair, with MTHI/MTLO write access.     |
// | Ports     : clk, RESET (async, active-low)                             |
// |             start, op[1:0], rs_val, rt_val - operation request         |
// |             wr_hi, wr_lo, wr_data          - MTHI/MTLO writes (idle)   |
// |             hi, lo                         - architectural HI/LO       |
// |             busy, done                     - status / completion pulse |
// | Config    : HILO_MULDIV_DIV_EN - enables DIV/DIVU; without it a start  |
// |             with op[1]=1 is ignored.                                   |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   part_hi, nxt_hi;
  logic [WIDTH-1:0] part_lo, nxt_lo;
  logic [WIDTH-1:0] operand;
  logic             neg_q;
  logic             signed_op, op_ok, accept;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef HILO_MULDIV_DIV_EN
  logic             div_q, neg_r, dz_q;
  logic [WIDTH-1:0] rs_q;
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  // Magnitudes are unsigned, so |-2^(W-1)| is representable.
  assign rs_mag = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign accept = start && (state == ST_IDLE) && op_ok;
  assign busy   = (state != ST_IDLE);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
`ifdef HILO_MULDIV_DIV_EN
    .is_div  (div_q),
`endif
    .part_hi (part_hi),
    .part_lo (part_lo),
    .operand (operand),
    .nxt_hi  (nxt_hi),
    .nxt_lo  (nxt_lo)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sign fix-up and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    prod = {part_hi[WIDTH-1:0], part_lo};
    if (neg_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef HILO_MULDIV_DIV_EN
    if (div_q) begin
      res_lo = neg_q ? -part_lo : part_lo;
      res_hi = neg_r ? -part_hi[WIDTH-1:0] : part_hi[WIDTH-1:0];
      if (dz_q) begin
        res_lo = {WIDTH{1'b1}};
        res_hi = rs_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt     <= '0;
      part_hi <= '0;
      part_lo <= '0;
      operand <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      div_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      rs_q    <= '0;
`endif
    end else begin
      done <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (accept) begin
            cnt     <= CW'(WIDTH - 1);
            part_hi <= '0;
            // Multiply shifts the multiplier out of part_lo; divide shifts
            // the dividend out while quotient bits shift in.
            part_lo <= op[1] ? rs_mag : rt_mag;
            operand <= op[1] ? rt_mag : rs_mag;
            neg_q   <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
`ifdef HILO_MULDIV_DIV_EN
            div_q   <= op[1];
            neg_r   <= signed_op && rs_val[WIDTH-1];
            dz_q    <= op[1] && (rt_val == '0);
            rs_q    <= rs_val;
`endif
          end
        end
        ST_RUN: begin
          part_hi <= nxt_hi;
          part_lo <= nxt_lo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
